// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side capture signals and consumer-side FWFT pop handshake.
// The slave modport is the FIFO's view; the master modport is the UART receiver plus the consumer.
`default_nettype none

interface uart_rx_fifo_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_error;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       rd_valid;
    logic       rd_en;

    modport master (
        output rx_data, rx_ready, rx_error, rd_en,
        input  rd_data, rd_err, rd_valid
    );

    modport slave (
        input  rx_data, rx_ready, rx_error, rd_en,
        output rd_data, rd_err, rd_valid
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: edge-detected UART byte capture into a circular FWFT FIFO with level/afull/overflow/error stats.
// Optional macro UART_RX_FIFO_ERR_KEEP_EN stores errored frames as 9-bit entries and exposes their error bit.
`default_nettype none

module uart_rx_fifo #(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  wire logic                   clk50m,
    input  wire logic                   rst_n,
    uart_rx_fifo_if.slave               bus,
    output logic [$clog2(DEPTH):0]      level_o,
    output logic                        afull_o,
    output logic                        overflow_o,
    output logic [7:0]                  err_cnt_o,
    input  wire logic                   stat_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
`ifdef UART_RX_FIFO_ERR_KEEP_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    logic          rdy_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;
    logic [7:0]    errc_q,   errc_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic          wr_stb;
    logic          wr_req;
    logic          pop;
    logic          not_full;
    logic          wr_acc;
    logic          wr_drop;
    logic          err_evt;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    assign wr_stb   = bus.rx_ready & ~rdy_q;
    assign err_evt  = wr_stb & bus.rx_error;

`ifdef UART_RX_FIFO_ERR_KEEP_EN
    assign wr_req   = wr_stb;
    assign wr_entry = {bus.rx_error, bus.rx_data};
`else
    // Errored frames are only counted, so they can never fill the FIFO or flag overflow.
    assign wr_req   = wr_stb & ~bus.rx_error;
    assign wr_entry = bus.rx_data;
`endif

    assign pop      = bus.rd_en & bus.rd_valid;
    assign not_full = (level_q < LW'(DEPTH));
    assign wr_acc   = wr_req & (not_full | pop);
    assign wr_drop  = wr_req & ~(not_full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        errc_d   = errc_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !wr_acc) begin
            level_d = level_q - LW'(1);
        end

        // Set/increment events take priority over a coincident clear.
        if (wr_drop) begin
            ovf_d = 1'b1;
        end else if (stat_clr_i) begin
            ovf_d = 1'b0;
        end

        if (err_evt) begin
            if (stat_clr_i) begin
                errc_d = 8'd1;
            end else if (errc_q != 8'hFF) begin
                errc_d = errc_q + 8'd1;
            end
        end else if (stat_clr_i) begin
            errc_d = 8'd0;
        end
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            errc_q   <= 8'd0;
        end else begin
            rdy_q    <= bus.rx_ready;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            errc_q   <= errc_d;
        end
    end

    // Storage is deliberately left out of reset; emptiness is tracked by level_q alone.
    always_ff @(posedge clk50m) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign bus.rd_data  = head[7:0];
`ifdef UART_RX_FIFO_ERR_KEEP_EN
    assign bus.rd_err   = head[8];
`else
    assign bus.rd_err   = 1'b0;
`endif
    assign bus.rd_valid = (level_q != '0);

    assign level_o    = level_q;
    assign afull_o    = (level_q >= LW'(AFULL_LVL));
    assign overflow_o = ovf_q;
    assign err_cnt_o  = errc_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (DEPTH=16, AFULL_LVL=12).
`default_nettype none

module tb_uart_rx_fifo;

    logic       clk50m = 1'b0;
    logic       rst_n  = 1'b0;
    logic [4:0] level_o;
    logic       afull_o;
    logic       overflow_o;
    logic [7:0] err_cnt_o;
    logic       stat_clr_i = 1'b0;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .DEPTH     (16),
        .AFULL_LVL (12)
    ) dut (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .bus        (bus),
        .level_o    (level_o),
        .afull_o    (afull_o),
        .overflow_o (overflow_o),
        .err_cnt_o  (err_cnt_o),
        .stat_clr_i (stat_clr_i)
    );

    always #5 clk50m = ~clk50m;

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One receiver frame: rx_ready rises for one cycle, then returns low.
    task automatic send(input logic [7:0] d, input logic e);
        bus.rx_data  = d;
        bus.rx_error = e;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
        tick();
    endtask

    task automatic pop1();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
        bus.rd_en    = 1'b0;

        tick();
        tick();
        chk("rst_level",    32'(level_o),    32'd0);
        chk("rst_valid",    32'(bus.rd_valid), 32'd0);
        chk("rst_afull",    32'(afull_o),    32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        chk("rst_errcnt",   32'(err_cnt_o),  32'd0);
        rst_n = 1'b1;
        tick();

        // Held rx_ready yields exactly one entry.
        bus.rx_data  = 8'hA5;
        bus.rx_ready = 1'b1;
        tick();
        chk("hold_valid_c1", 32'(bus.rd_valid), 32'd1);
        chk("hold_level_c1", 32'(level_o),      32'd1);
        chk("hold_data",     32'(bus.rd_data),  32'hA5);
        for (int i = 0; i < 49; i++) tick();
        chk("hold_level_50", 32'(level_o), 32'd1);
        bus.rx_ready = 1'b0;
        tick();
        pop1();
        chk("hold_pop_valid", 32'(bus.rd_valid), 32'd0);
        chk("hold_pop_level", 32'(level_o),      32'd0);

        // Fill 0x00..0x0F; afull asserts at level 12.
        for (int i = 0; i < 16; i++) begin
            send(8'(i), 1'b0);
            if (i == 10) chk("afull_at11", 32'(afull_o), 32'd0);
            if (i == 11) chk("afull_at12", 32'(afull_o), 32'd1);
        end
        chk("full_level", 32'(level_o), 32'd16);

        send(8'h77, 1'b0);
        chk("ovf_flag",  32'(overflow_o),  32'd1);
        chk("ovf_level", 32'(level_o),     32'd16);
        chk("ovf_head",  32'(bus.rd_data), 32'h00);

        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_%0d", i), 32'(bus.rd_data), 32'(i));
            pop1();
        end
        chk("drain_valid", 32'(bus.rd_valid), 32'd0);
        chk("drain_level", 32'(level_o),      32'd0);
        chk("drain_afull", 32'(afull_o),      32'd0);

        stat_clr_i = 1'b1;
        tick();
        stat_clr_i = 1'b0;
        chk("clr_overflow", 32'(overflow_o), 32'd0);

        // Full FIFO with write and pop in the same cycle.
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b0);
        bus.rx_data  = 8'h77;
        bus.rx_ready = 1'b1;
        bus.rd_en    = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        bus.rd_en    = 1'b0;
        chk("wrpop_level", 32'(level_o),     32'd16);
        chk("wrpop_ovf",   32'(overflow_o),  32'd0);
        chk("wrpop_head",  32'(bus.rd_data), 32'h11);
        tick();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("wrpop_drain_%0d", i), 32'(bus.rd_data), 32'(8'h11 + i));
            pop1();
        end
        chk("wrpop_last", 32'(bus.rd_data), 32'h77);
        pop1();
        chk("wrpop_empty", 32'(bus.rd_valid), 32'd0);

        // Error frames.
        send(8'h3C, 1'b1);
        chk("err_cnt1", 32'(err_cnt_o), 32'd1);
`ifdef UART_RX_FIFO_ERR_KEEP_EN
        chk("err_stored_level", 32'(level_o),     32'd1);
        chk("err_stored_rderr", 32'(bus.rd_err),  32'd1);
        chk("err_stored_data",  32'(bus.rd_data), 32'h3C);
        pop1();
`else
        chk("err_drop_level", 32'(level_o),      32'd0);
        chk("err_drop_valid", 32'(bus.rd_valid), 32'd0);
`endif
        bus.rx_data  = 8'h3D;
        bus.rx_error = 1'b1;
        bus.rx_ready = 1'b1;
        stat_clr_i   = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
        stat_clr_i   = 1'b0;
        chk("err_clr_coincide", 32'(err_cnt_o), 32'd1);
        tick();
`ifdef UART_RX_FIFO_ERR_KEEP_EN
        pop1();
`endif

        // Saturation: 1 + 260 error frames must stop at 255.
        for (int i = 0; i < 260; i++) send(8'hEE, 1'b1);
        chk("err_saturate", 32'(err_cnt_o), 32'd255);

        // Clean restart, then asynchronous reset with level=5.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send(8'(8'hE0 + i), 1'b0);
        chk("pre_rst_level", 32'(level_o), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", 32'(level_o),      32'd0);
        chk("async_rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("async_rst_ovf",   32'(overflow_o),   32'd0);
        chk("async_rst_errc",  32'(err_cnt_o),    32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) pop1();
        chk("empty_pop_level", 32'(level_o),      32'd0);
        chk("empty_pop_valid", 32'(bus.rd_valid), 32'd0);
        send(8'h5A, 1'b0);
        chk("empty_pop_ptr_data",  32'(bus.rd_data), 32'h5A);
        chk("empty_pop_ptr_level", 32'(level_o),     32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
